// File: rtl/irq_pkg.sv
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared state encoding and helpers for the interrupt controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int VEC_STRIDE_LOG2 = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_encoder.sv
// ============================================================================
//  Module   : irq_prio_encoder
//  Purpose  : Fixed-priority encoder, lowest set index wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_encoder #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] eff_i,
    output logic               sel_valid_o,
    output logic [ID_W-1:0]    sel_id_o
);

    // Scan from the top down so the last hit (lowest index) is kept
    always_comb begin
        sel_valid_o = 1'b0;
        sel_id_o    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff_i[i]) begin
                sel_valid_o = 1'b1;
                sel_id_o    = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_priority_ctrl.sv
// ============================================================================
//  Module   : irq_priority_ctrl
//  Purpose  : Non-nesting interrupt arbiter/sequencer feeding the flush control.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 8,
    parameter int ID_W    = clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_edge_mode,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic [XLEN-1:0]    vec_base,
    input  logic               vectored_mode,
    input  logic               irq_taken,
    input  logic               flush_busy,
    input  logic               mret,
    output logic               interrupt_pending,
    output logic [XLEN-1:0]    interrupt_vector,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [ID_W-1:0]    active_id,
    output logic               spurious_ack
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] src_prev_q;
    logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [XLEN-1:0]    vec_q, vec_d;
    logic               in_service_q, in_service_d;
    logic               spurious_q, spurious_d;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_eff;
    logic               w_sel_valid;
    logic [ID_W-1:0]    w_sel_id;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_offset;
    logic               w_unused;

    // flush_busy is status only; the low base bits are forced to zero
    assign w_unused = &{1'b0, flush_busy, vec_base[1:0]};

    assign w_rise   = irq_src & ~src_prev_q;
    assign w_eff    = irq_mask & ((irq_edge_mode & edge_pend_q) | (~irq_edge_mode & irq_src));
    assign w_base   = {vec_base[XLEN-1:2], 2'b00};
    assign w_offset = XLEN'(w_sel_id) << VEC_STRIDE_LOG2;

    irq_prio_encoder #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_enc (
        .eff_i       (w_eff),
        .sel_valid_o (w_sel_valid),
        .sel_id_o    (w_sel_id)
    );

    always_comb begin
        state_d      = state_q;
        edge_pend_d  = edge_pend_q;
        irq_id_d     = irq_id_q;
        active_id_d  = active_id_q;
        vec_d        = vec_q;
        in_service_d = in_service_q;
        spurious_d   = spurious_q;

        case (state_q)
            IDLE: begin
                if (w_sel_valid) begin
                    state_d  = REQ;
                    irq_id_d = w_sel_id;
                    vec_d    = vectored_mode ? (w_base + w_offset) : w_base;
                end
            end
            REQ: begin
                if (irq_taken) begin
                    state_d      = SERVICE;
                    active_id_d  = irq_id_q;
                    in_service_d = 1'b1;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (irq_edge_mode[i] && (ID_W'(i) == irq_id_q))
                            edge_pend_d[i] = 1'b0;
                    end
                end
            end
            SERVICE: begin
                if (mret) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (irq_taken && (state_q != REQ))
            spurious_d = 1'b1;

        // A fresh edge in the acknowledge cycle must survive the clear above
        edge_pend_d = edge_pend_d | (w_rise & irq_edge_mode);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_prev_q   <= '0;
            edge_pend_q  <= '0;
            irq_id_q     <= '0;
            active_id_q  <= '0;
            vec_q        <= '0;
            in_service_q <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_prev_q   <= irq_src;
            edge_pend_q  <= edge_pend_d;
            irq_id_q     <= irq_id_d;
            active_id_q  <= active_id_d;
            vec_q        <= vec_d;
            in_service_q <= in_service_d;
            spurious_q   <= spurious_d;
        end
    end

    assign interrupt_pending = (state_q == REQ);
    assign interrupt_vector  = vec_q;
    assign irq_id            = irq_id_q;
    assign in_service        = in_service_q;
    assign active_id         = active_id_q;
    assign spurious_ack      = spurious_q;

endmodule

`default_nettype wire
